// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 frame scheduler and serial driver:
// FSM encoding, pixel field layout, driver timing and brightness scaling.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        KICK      = 2'd1,
        WAIT_BUSY = 2'd2,
        STREAM    = 2'd3
    } state_t;

    localparam int PIXEL_W = 24;
    localparam int R_LSB   = 16;
    localparam int G_LSB   = 8;
    localparam int B_LSB   = 0;

    // Driver bit period (1.25 us) and latch interval (80 us) at 50 MHz.
    localparam int CYCLE_COUNT = 62;
    localparam int RESET_COUNT = 4000;

    // (c * (b + 1)) >> 8: b = 255 is identity, b = 0 blanks every channel.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Two-bank pixel store: one write port, one registered read port.
// The bank bit is the address MSB so each bank is a contiguous half.
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic               rd_bank,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** (ADDR_W + 1);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic               wr_ok;

    assign wr_ok = wr_en && (int'(wr_addr) < NUM_LEDS);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    // Holds between requests so the driver may sample late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler: swaps pixel banks on commit, resends periodically,
// kicks the serial driver and feeds it brightness-scaled RGB.
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int  NUM_LEDS     = 8,
    parameter int  SYSTEM_CLOCK = 50_000_000,
    parameter int  REFRESH_HZ   = 60,
    localparam int ADDR_W       = $clog2(NUM_LEDS)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [23:0]       wr_data_i,
    input  logic              commit_i,
    input  logic              refresh_en_i,
    input  logic [7:0]        brightness_i,
    input  logic [ADDR_W-1:0] led_count_i,
    output logic              front_bank_o,
    output logic              pending_o,
    output logic              frame_done_o,
    output logic              drv_start_o,
    input  logic              drv_busy_i,
    input  logic              drv_data_request_i,
    input  logic [ADDR_W-1:0] drv_address_i,
    output logic [7:0]        drv_red_o,
    output logic [7:0]        drv_green_o,
    output logic [7:0]        drv_blue_o,
    output logic [ADDR_W-1:0] drv_led_count_o
);

    localparam int REFRESH_CYCLES = SYSTEM_CLOCK / REFRESH_HZ;
    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    state_t              state, state_nxt;
    logic                front_bank;
    logic                commit_pend, refresh_pend;
    logic [TW-1:0]       timer;
    logic                wrap;
    logic                go;
    logic [ADDR_W-1:0]   led_count;
    logic [PIXEL_W-1:0]  pix;

    assign pending_o = commit_pend | refresh_pend;
    assign go        = (state == IDLE) && pending_o && !drv_busy_i;
    assign wrap      = (timer == TW'(REFRESH_CYCLES - 1));

    ws2812_pixel_ram #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .wr_en   (wr_en_i),
        .wr_bank (~front_bank),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_en   (drv_data_request_i),
        .rd_bank (front_bank),
        .rd_addr (drv_address_i),
        .rd_data (pix)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (go)          state_nxt = KICK;
            KICK:                       state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (drv_busy_i)  state_nxt = STREAM;
            STREAM:    if (!drv_busy_i) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        drv_start_o  = (state == KICK);
        frame_done_o = (state == STREAM) && !drv_busy_i;
    end

    // New events win over the clear on frame start, so nothing is lost.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            front_bank   <= 1'b0;
            commit_pend  <= 1'b0;
            refresh_pend <= 1'b0;
            led_count    <= '0;
        end else begin
            if (go) begin
                if (commit_pend) front_bank <= ~front_bank;
                led_count <= led_count_i;
            end
            commit_pend  <= commit_i | (commit_pend & ~go);
            refresh_pend <= (wrap & refresh_en_i) | (refresh_pend & ~go);
        end
    end

    // Free-running; a commit does not realign the refresh phase.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)  timer <= '0;
        else if (wrap)  timer <= '0;
        else            timer <= timer + TW'(1);
    end

    assign front_bank_o    = front_bank;
    assign drv_led_count_o = led_count;
    assign drv_red_o       = scale8(pix[R_LSB +: 8], brightness_i);
    assign drv_green_o     = scale8(pix[G_LSB +: 8], brightness_i);
    assign drv_blue_o      = scale8(pix[B_LSB +: 8], brightness_i);

endmodule

// File: doc/ws2812_frame_sched.md
Name: ws2812_frame_sched

Overview:
Frame-level controller for the ws2812 serial driver. It owns a double-buffered pixel RAM that the SPI host writes into. It decides when a frame is sent, either on host commit or on a periodic refresh. It issues the driver start pulse, serves the driver's data requests with brightness-scaled RGB, and reports frame completion back to the host side.

Parameters:
NUM_LEDS, 8, LEDs in chain; ADDR_W = $clog2(NUM_LEDS)
SYSTEM_CLOCK, 50_000_000, clock frequency in Hz
REFRESH_HZ, 60, auto-refresh rate; REFRESH_CYCLES = SYSTEM_CLOCK / REFRESH_HZ

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous, active-low reset
wr_en_i  in  1  host pixel write strobe; always targets the back bank
wr_addr_i  in  ADDR_W  pixel index
wr_data_i  in  24  {red, green, blue}
commit_i  in  1  pulse: back bank is complete; swap banks and send a frame
refresh_en_i  in  1  enable periodic resend of the front bank
brightness_i  in  8  global scale; 255 = full
led_count_i  in  ADDR_W  active LED count, passed to the driver
front_bank_o  out  1  bank currently displayed
pending_o  out  1  a frame is queued and not yet started
frame_done_o  out  1  one-cycle pulse at end of each frame
drv_start_o  out  1  driver start (driver detects the rising edge)
drv_busy_i  in  1  driver busy
drv_data_request_i  in  1  driver request; RGB is sampled on the following cycle
drv_address_i  in  ADDR_W  LED index for the current request
drv_red_o, drv_green_o, drv_blue_o  out  8 each  scaled pixel data
drv_led_count_o  out  ADDR_W  led_count_i, latched at frame start

Behaviour:
- Reset (async, reset_ni=0): state IDLE; front_bank_o=0; pending flags=0; refresh timer=0; drv_start_o=0; frame_done_o=0; RAM output register=0, so drv_*_o=0; drv_led_count_o=0. RAM contents are undefined. Reset mid-frame aborts immediately; the driver is reset separately.
- RAM: 2*NUM_LEDS x 24. Write port at address {~front_bank, wr_addr_i}. Read port is synchronous with 1-cycle latency.
  - Read occurs when drv_data_request_i=1, at address {front_bank, drv_address_i}.
  - The read register holds its value otherwise, so RGB is valid in the cycle after the request and stable until the next request.
  - wr_addr_i >= NUM_LEDS: write ignored.
- Scaling (combinational on the read register): out = (c * (brightness_i + 1)) >> 8, 16-bit product, upper byte taken. 255 gives identity; 0 gives 0 for all c.
- Pending sources:
  - commit_i sets commit_pend.
  - Refresh timer counts 0..REFRESH_CYCLES-1 continuously and wraps. At wrap it sets refresh_pend if refresh_en_i=1.
  - pending_o = commit_pend | refresh_pend.
  - Events arriving while a frame is in progress stay pending (coalesced, never lost). The timer does not reset on commit.
- FSM:
  - IDLE: when pending_o=1 and drv_busy_i=0, go to KICK. If commit_pend, toggle front_bank. Clear both pending flags. Latch drv_led_count_o.
  - KICK: drv_start_o=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for drv_busy_i=1 (the driver may hold up to about 80 us for its reset interval). Then go to STREAM.
  - STREAM: wait for drv_busy_i=0. Then pulse frame_done_o for one cycle and go to IDLE.
  - A commit arriving in the same cycle the FSM leaves IDLE is captured as pending for the next frame. The swap already in progress is unaffected.
  - front_bank changes only in IDLE, so a frame never tears.
- Host writes are accepted in every state without stall. Writing the back bank during a frame is legal.

Decomposition:
- Package ws2812_pkg: state encoding (IDLE, KICK, WAIT_BUSY, STREAM); the {R,G,B} pixel field offsets; CYCLE_COUNT and RESET_COUNT timing constants, shared with the driver.
- One natural sub-module, ws2812_pixel_ram: dual-bank 1W/1R synchronous RAM with the bank-select address mapping.
- Brightness scaling and the FSM stay in the top module.

Test Plan:
- Write LED0..2 of the back bank with 0xFF0000, 0x00FF00, 0x0000FF; commit_i; brightness 255 -> front_bank_o=1; one drv_start_o pulse; driver sees R/G/B bytes FF,00,00 / 00,FF,00 / 00,00,FF in order; one frame_done_o.
- Brightness 127, pixel 0xFFFFFF -> drv_*_o=0x7F. Brightness 0 -> 0x00. Brightness 255, pixel 0x010101 -> 0x01.
- commit_i pulsed twice during STREAM -> pending_o=1; exactly one further frame after frame_done_o; banks toggle once per frame start.
- refresh_en_i=1, REFRESH_HZ reduced for simulation, no commits -> frames repeat each period; front_bank_o is unchanged.
- Hold drv_busy_i low for 4000 cycles after KICK -> FSM stays in WAIT_BUSY; no second start; no frame_done_o.
- Assert reset_ni low during STREAM -> all outputs are at reset values in the same cycle; no frame_done_o.
